poly_mult_dummy_sched: RTL

Sequencer for the dummy-insertion sparse polynomial multiplier. It reads the WEIGHT real support positions from the position RAM and random words from the random-bits RAM. It then emits MAX_WEIGHT operations to the multiply datapath, with (MAX_WEIGHT-WEIGHT) dummy operations interleaved at random-bit-selected slots. The datapath sees a constant operation count regardless of the secret pattern. It sits between the host load interface/RAMs and the shift-accumulate datapath.

---
 rtl/poly_mult_dummy_sched.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/poly_mult_dummy_sched.sv
// Sequencer for the dummy-insertion sparse polynomial multiplier: interleaves
// MAX_WEIGHT-WEIGHT dummy operations among WEIGHT real ones using random bits.
module poly_mult_dummy_sched #(
    parameter int unsigned WEIGHT         = 66,
    parameter int unsigned MAX_WEIGHT     = 75,
    parameter int unsigned LOGW           = 16,
    parameter int unsigned RAMWIDTH       = 32,
    parameter int unsigned LOG_WEIGHT     = 7,
    parameter int unsigned LOG_MAX_WEIGHT = 7,
    parameter int unsigned RND_ADDR_WIDTH = 10,
    parameter int unsigned RND_BASE       = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      pos_rd_o,
    output logic [LOG_WEIGHT-1:0]     pos_addr_o,
    input  logic [LOGW-1:0]           pos_data_i,
    output logic                      rnd_rd_o,
    output logic [RND_ADDR_WIDTH-1:0] rnd_addr_o,
    input  logic [RAMWIDTH-1:0]       rnd_data_i,
    output logic                      op_valid_o,
    input  logic                      op_ready_i,
    output logic [LOGW-1:0]           op_pos_o,
    output logic                      op_dummy_o,
    output logic [LOG_MAX_WEIGHT-1:0] op_idx_o
);

    localparam int unsigned BPW = $clog2(RAMWIDTH);
    localparam logic [LOG_WEIGHT-1:0]     WEIGHT_C  = LOG_WEIGHT'(WEIGHT);
    localparam logic [LOG_WEIGHT-1:0]     WEIGHT_M1 = LOG_WEIGHT'(WEIGHT - 1);
    localparam logic [LOG_MAX_WEIGHT-1:0] NDUM_C    = LOG_MAX_WEIGHT'(MAX_WEIGHT - WEIGHT);
    localparam logic [LOG_MAX_WEIGHT-1:0] LAST_SLOT = LOG_MAX_WEIGHT'(MAX_WEIGHT - 1);
    localparam logic [BPW-1:0]            LAST_BIT  = BPW'(RAMWIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, RND_REQ, RND_WAIT, POS_REQ, POS_WAIT, DECIDE, ISSUE, DONE
    } state_t;

    state_t state, state_nxt;

    logic [LOG_WEIGHT-1:0]     real_cnt;
    logic [LOG_MAX_WEIGHT-1:0] dum_cnt;
    logic [LOG_MAX_WEIGHT-1:0] slot;
    logic [RAMWIDTH-1:0]       rnd_buf;
    logic [BPW-1:0]            bit_ptr;
    logic [LOGW-1:0]           pos_buf;
    logic                      pos_valid;
    logic [RND_ADDR_WIDTH-1:0] rnd_word_addr;
    logic                      is_dummy;
    logic                      handshake;

    // Forced choices still occupy their bit position so timing is data-independent.
    assign is_dummy  = (real_cnt == WEIGHT_C) ? 1'b1 :
                       (dum_cnt == NDUM_C)    ? 1'b0 : rnd_buf[bit_ptr];
    assign handshake = op_valid_o && op_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy_o     = (state != IDLE);
        done_o     = 1'b0;
        pos_rd_o   = 1'b0;
        pos_addr_o = '0;
        rnd_rd_o   = 1'b0;
        rnd_addr_o = '0;
        unique case (state)
            IDLE:     if (start_i) state_nxt = RND_REQ;
            RND_REQ: begin
                rnd_rd_o   = 1'b1;
                rnd_addr_o = rnd_word_addr;
                state_nxt  = RND_WAIT;
            end
            RND_WAIT: state_nxt = (!pos_valid && real_cnt < WEIGHT_C) ? POS_REQ : DECIDE;
            POS_REQ: begin
                pos_rd_o   = 1'b1;
                pos_addr_o = real_cnt;
                state_nxt  = POS_WAIT;
            end
            POS_WAIT: state_nxt = DECIDE;
            DECIDE:   state_nxt = ISSUE;
            ISSUE: begin
                if (handshake) begin
                    if (slot == LAST_SLOT)                          state_nxt = DONE;
                    else if (bit_ptr == LAST_BIT)                   state_nxt = RND_REQ;
                    else if (!op_dummy_o && real_cnt < WEIGHT_M1)   state_nxt = POS_REQ;
                    else                                            state_nxt = DECIDE;
                end
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            real_cnt      <= '0;
            dum_cnt       <= '0;
            slot          <= '0;
            rnd_buf       <= '0;
            bit_ptr       <= '0;
            pos_buf       <= '0;
            pos_valid     <= 1'b0;
            rnd_word_addr <= '0;
            op_valid_o    <= 1'b0;
            op_pos_o      <= '0;
            op_dummy_o    <= 1'b0;
            op_idx_o      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        real_cnt      <= '0;
                        dum_cnt       <= '0;
                        slot          <= '0;
                        bit_ptr       <= '0;
                        pos_valid     <= 1'b0;
                        rnd_word_addr <= RND_ADDR_WIDTH'(RND_BASE);
                    end
                end
                RND_WAIT: begin
                    rnd_buf       <= rnd_data_i;
                    bit_ptr       <= '0;
                    rnd_word_addr <= rnd_word_addr + RND_ADDR_WIDTH'(1);
                end
                POS_WAIT: begin
                    pos_buf   <= pos_data_i;
                    pos_valid <= 1'b1;
                end
                DECIDE: begin
                    op_pos_o   <= is_dummy ? rnd_buf[LOGW-1:0] : pos_buf;
                    op_dummy_o <= is_dummy;
                    op_idx_o   <= slot;
                    op_valid_o <= 1'b1;
                end
                ISSUE: begin
                    if (handshake) begin
                        op_valid_o <= 1'b0;
                        slot       <= slot + LOG_MAX_WEIGHT'(1);
                        bit_ptr    <= bit_ptr + BPW'(1);
                        if (op_dummy_o) begin
                            dum_cnt <= dum_cnt + LOG_MAX_WEIGHT'(1);
                        end else begin
                            real_cnt  <= real_cnt + LOG_WEIGHT'(1);
                            pos_valid <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
